mult_feeder: RTL

- Upstream/downstream companion stage for the 8x8 signed sequential (Robertson's) multiplier.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues them one at a time to the multiplier, waits for its done flag, and presents each 16-bit product on a valid/ready output stream.
- Supervises the multiplier with a watchdog timeout.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_feeder_fifo.sv | 64 ++++++
 rtl/mult_feeder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier feeder stage.
package mult_pkg;

   typedef logic signed [7:0]  operand_t;
   typedef logic signed [15:0] product_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      GUARD,
      WAIT
   } feeder_state_t;

   localparam product_t TIMEOUT_PRODUCT = 16'h8000;

endpackage

// File: rtl/mult_feeder_fifo.sv
// Small operand FIFO for the multiplier feeder.
// DEPTH must be a power of two so the pointers wrap on their own.
module mult_feeder_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;

   // Storage array; contents need no reset because the count defines what is valid.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_doPop && !w_doPush) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   assign o_data  = r_mem[r_rdPtr];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/mult_feeder.sv
// Feeder stage for the 8x8 signed sequential multiplier: buffers operand
// pairs, issues them one at a time, supervises each op with a watchdog and
// presents products on a valid/ready stream.
// Optional macro SELF_CHECK_EN adds a reference multiplier and a sticky
// check_err output.
module mult_feeder
   import mult_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_multiplier,
   input  logic [7:0]  in_multiplicand,
   output logic        mult_start,
   output logic [7:0]  mult_multiplier,
   output logic [7:0]  mult_multiplicand,
   input  logic [15:0] mult_product,
   input  logic        mult_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_product,
   output logic        busy,
   output logic        timeout_err
`ifdef SELF_CHECK_EN
   ,
   output logic        check_err
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   feeder_state_t    r_state;
   logic             r_multStart;
   operand_t         r_multiplier;
   operand_t         r_multiplicand;
   logic [WD_W-1:0]  r_wdCount;
   logic             r_outValid;
   logic [15:0]      r_outProduct;
   logic             r_timeoutErr;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_slotFree;
   logic [15:0]      w_fifoHead;
   logic [CNT_W-1:0] w_fifoCount;

   assign w_push     = in_valid && !w_full;
   assign w_slotFree = !r_outValid || out_ready;
   assign w_pop      = (r_state == IDLE) && !w_empty && w_slotFree;

   mult_feeder_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  ({in_multiplier, in_multiplicand}),
      .o_data  (w_fifoHead),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_fifoCount)
   );

   // Sequencer: pops the head on entry to START so operands are stable for the
   // whole START..capture window, skips the stale done in GUARD, then waits for
   // done or the watchdog. Output slot handshake lives here as well.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_multStart    <= 1'b0;
         r_multiplier   <= '0;
         r_multiplicand <= '0;
         r_wdCount      <= '0;
         r_outValid     <= 1'b0;
         r_outProduct   <= '0;
         r_timeoutErr   <= 1'b0;
      end else begin
         r_multStart <= 1'b0;
         if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_state                          <= START;
                  r_multStart                      <= 1'b1;
                  {r_multiplier, r_multiplicand}   <= w_fifoHead;
               end
            end
            START: begin
               r_state   <= GUARD;
               r_wdCount <= '0;
            end
            GUARD: begin
               r_state <= WAIT;
            end
            WAIT: begin
               if (mult_done) begin
                  r_outProduct <= mult_product;
                  r_outValid   <= 1'b1;
                  r_state      <= IDLE;
               end else if (r_wdCount == WD_W'(TIMEOUT - 1)) begin
                  r_outProduct <= TIMEOUT_PRODUCT;
                  r_outValid   <= 1'b1;
                  r_timeoutErr <= 1'b1;
                  r_state      <= IDLE;
               end else begin
                  r_wdCount <= r_wdCount + WD_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready          = !w_full;
   assign mult_start        = r_multStart;
   assign mult_multiplier   = r_multiplier;
   assign mult_multiplicand = r_multiplicand;
   assign out_valid         = r_outValid;
   assign out_product       = r_outProduct;
   assign timeout_err       = r_timeoutErr;
   assign busy              = (r_state != IDLE) || (w_fifoCount != '0);

`ifdef SELF_CHECK_EN
   product_t w_refProduct;
   logic     r_checkErr;

   assign w_refProduct = product_t'(r_multiplier) * product_t'(r_multiplicand);

   // Sticky flag raised when a genuinely captured product disagrees with the reference.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_checkErr <= 1'b0;
      end else if ((r_state == WAIT) && mult_done && (mult_product != w_refProduct)) begin
         r_checkErr <= 1'b1;
      end
   end

   assign check_err = r_checkErr;
`endif

endmodule
